// File: rtl/xilly_src_pkg.sv
// Shared defaults and helpers for the Xillybus 128-bit read-stream source.
package xilly_src_pkg;

  localparam int DEF_WORD_W = 128;
  localparam int DEF_DEPTH  = 16;

  // Width of an occupancy counter that can represent 0..depth inclusive.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/xilly_src_fifo.sv
// Synchronous FIFO with a registered (non-FWFT) read port and a synchronous
// flush. The caller gates wr_en and rd_en: wr_en only when not full, rd_en
// only when not empty.
module xilly_src_fifo
  import xilly_src_pkg::*;
#(
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int WORD_W = DEF_WORD_W,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int LVL_W  = level_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] din,
  input  logic              rd_en,
  output logic [WORD_W-1:0] dout,
  output logic [LVL_W-1:0]  count
);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Storage array: plain RAM, never reset, skipped while flushing.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally at DEPTH; the read register only moves on a read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr];
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/xilly_read_source.sv
// Application-side source for one Xillybus 128-bit read stream. Buffers words
// from an ap_fifo-style producer and serves them on the user_r_read_128_*
// handshake, with open/close flushing and end-of-file signalling.
// Optional feature: define XILLY_SRC_WORDCOUNT_EN to build the 32-bit
// delivered-word counter; otherwise word_count is tied to zero.
module xilly_read_source
  import xilly_src_pkg::*;
#(
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int WORD_W = DEF_WORD_W,
  localparam int LVL_W  = level_w(DEPTH)
) (
  input  logic              bus_clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] ap_din,
  input  logic              ap_write,
  output logic              ap_full_n,
  input  logic              eof_req,
  input  logic              user_r_read_128_rden,
  output logic [WORD_W-1:0] user_r_read_128_data,
  output logic              user_r_read_128_empty,
  output logic              user_r_read_128_eof,
  input  logic              user_r_read_128_open,
  output logic [LVL_W-1:0]  level,
  output logic [31:0]       word_count
);

  logic             wr_acc;
  logic             rd_acc;
  logic             flush;
  logic             eof_pending;
  logic             eof_pending_nxt;
  logic [LVL_W-1:0] level_nxt;

  assign flush  = !user_r_read_128_open;
  assign wr_acc = ap_write && ap_full_n;
  assign rd_acc = user_r_read_128_rden && !user_r_read_128_empty;

  assign user_r_read_128_empty = (level == '0);
  assign user_r_read_128_eof   = eof_pending && user_r_read_128_empty;

  xilly_src_fifo #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W)
  ) u_fifo (
    .clk   (bus_clk),
    .rst   (rst),
    .flush (flush),
    .wr_en (wr_acc),
    .din   (ap_din),
    .rd_en (rd_acc),
    .dout  (user_r_read_128_data),
    .count (level)
  );

  // Look-ahead of the state after this edge, so ap_full_n can be registered
  // and still recover in the cycle right after a read frees a full buffer.
  always_comb begin
    level_nxt       = '0;
    eof_pending_nxt = 1'b0;
    if (user_r_read_128_open) begin
      level_nxt       = level + LVL_W'(wr_acc) - LVL_W'(rd_acc);
      eof_pending_nxt = eof_pending || eof_req;
    end
  end

  // EOF latch: armed by eof_req while open, cleared only by close or reset.
  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      eof_pending <= 1'b0;
    end else begin
      eof_pending <= eof_pending_nxt;
    end
  end

  // Producer back-pressure, registered so the core's rden never reaches it
  // combinationally.
  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      ap_full_n <= 1'b0;
    end else begin
      ap_full_n <= user_r_read_128_open && (level_nxt != LVL_W'(DEPTH)) &&
                   !eof_pending_nxt;
    end
  end

`ifdef XILLY_SRC_WORDCOUNT_EN
  logic [31:0] wc;

  // Delivered-word counter, wraps at 2^32 and restarts on every close.
  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      wc <= '0;
    end else if (flush) begin
      wc <= '0;
    end else if (rd_acc) begin
      wc <= wc + 32'd1;
    end
  end

  assign word_count = wc;
`else
  assign word_count = '0;
`endif

endmodule

// File: tb/tb_xilly_read_source.sv
// Self-checking bench for xilly_read_source against a queue-based model.
module tb_xilly_read_source;

  localparam int DEPTH  = 16;
  localparam int WORD_W = 128;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic              bus_clk = 1'b0;
  logic              rst;
  logic [WORD_W-1:0] ap_din;
  logic              ap_write;
  logic              ap_full_n;
  logic              eof_req;
  logic              rden;
  logic [WORD_W-1:0] rdata;
  logic              empty;
  logic              eof;
  logic              open;
  logic [LVL_W-1:0]  level;
  logic [31:0]       word_count;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [WORD_W-1:0] q[$];
  logic [WORD_W-1:0] m_data;
  bit                m_eofp;
  bit                m_full_n;
  logic [31:0]       m_wc;

  xilly_read_source #(.DEPTH(DEPTH), .WORD_W(WORD_W)) dut (
    .bus_clk               (bus_clk),
    .rst                   (rst),
    .ap_din                (ap_din),
    .ap_write              (ap_write),
    .ap_full_n             (ap_full_n),
    .eof_req               (eof_req),
    .user_r_read_128_rden  (rden),
    .user_r_read_128_data  (rdata),
    .user_r_read_128_empty (empty),
    .user_r_read_128_eof   (eof),
    .user_r_read_128_open  (open),
    .level                 (level),
    .word_count            (word_count)
  );

  always #5 bus_clk = ~bus_clk;

  function automatic logic [WORD_W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [31:0] exp_wc();
`ifdef XILLY_SRC_WORDCOUNT_EN
    return m_wc;
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    m_data   = '0;
    m_eofp   = 1'b0;
    m_full_n = 1'b0;
    m_wc     = '0;
  endtask

  // Drive one cycle of stimulus, advance the model by the same edge, sample #1 after.
  task automatic cyc(input bit w, input logic [WORD_W-1:0] d, input bit r, input bit e);
    bit rd_ok;
    bit wr_ok;
    ap_write = w;
    ap_din   = d;
    rden     = r;
    eof_req  = e;
    if (!open) begin
      q.delete();
      m_data = '0;
      m_eofp = 1'b0;
      m_wc   = '0;
    end else begin
      rd_ok = r && (q.size() > 0);
      wr_ok = w && m_full_n;
      if (rd_ok) begin
        m_data = q.pop_front();
        m_wc   = m_wc + 32'd1;
      end
      if (wr_ok) q.push_back(d);
      if (e) m_eofp = 1'b1;
    end
    m_full_n = open && (q.size() < DEPTH) && !m_eofp;
    @(posedge bus_clk);
    #1;
    ap_write = 1'b0;
    rden     = 1'b0;
    eof_req  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; open = 1'b1; ap_write = 0; ap_din = '0; rden = 0; eof_req = 0;
    model_reset();
    #2;
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got=%b exp=1", empty); end
    n_cmp++; if (eof !== 1'b0) begin n_err++; $display("FAIL reset_eof got=%b exp=0", eof); end
    n_cmp++; if (ap_full_n !== 1'b0) begin n_err++; $display("FAIL reset_full_n got=%b exp=0", ap_full_n); end
    n_cmp++; if (rdata !== '0) begin n_err++; $display("FAIL reset_data got=%h exp=0", rdata); end
    n_cmp++; if (level !== '0) begin n_err++; $display("FAIL reset_level got=%0d exp=0", level); end
    n_cmp++; if (word_count !== 32'd0) begin n_err++; $display("FAIL reset_wc got=%0d exp=0", word_count); end
    @(posedge bus_clk); #1;
    rst = 1'b0;
    n_cmp++; if (ap_full_n !== 1'b0) begin n_err++; $display("FAIL reset_full_n_held got=%b exp=0", ap_full_n); end
    cyc(0, '0, 0, 0);
    n_cmp++; if (ap_full_n !== 1'b1) begin n_err++; $display("FAIL reset_full_n_first_edge got=%b exp=1", ap_full_n); end
    n_cmp++; if (empty !== 1'b1 || eof !== 1'b0) begin n_err++; $display("FAIL reset_idle got=%b%b exp=10", empty, eof); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(1, WORD_W'(i), 0, 0);
      n_cmp++; if (level !== LVL_W'(i)) begin n_err++; $display("FAIL fill_level got=%0d exp=%0d", level, i); end
    end
    n_cmp++; if (ap_full_n !== 1'b0) begin n_err++; $display("FAIL fill_full_n got=%b exp=0", ap_full_n); end
    cyc(1, WORD_W'(17), 0, 0);
    n_cmp++; if (level !== LVL_W'(DEPTH)) begin n_err++; $display("FAIL fill_drop_level got=%0d exp=%0d", level, DEPTH); end
    n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL fill_empty got=%b exp=0", empty); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(0, '0, 1, 0);
      n_cmp++; if (rdata !== WORD_W'(i)) begin n_err++; $display("FAIL drain_data got=%h exp=%h", rdata, WORD_W'(i)); end
      if (i == 1) begin
        n_cmp++; if (ap_full_n !== 1'b1) begin n_err++; $display("FAIL drain_full_recover got=%b exp=1", ap_full_n); end
      end
    end
    n_cmp++; if (empty !== 1'b1 || level !== '0) begin n_err++; $display("FAIL drain_empty got=%b/%0d exp=1/0", empty, level); end
    cyc(0, '0, 1, 0);
    n_cmp++; if (rdata !== WORD_W'(16)) begin n_err++; $display("FAIL drain_rden_empty got=%h exp=10", rdata); end
    n_cmp++; if (level !== '0) begin n_err++; $display("FAIL drain_rden_empty_level got=%0d exp=0", level); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) cyc(1, rnd128(), 0, 0);
    n_cmp++; if (level !== LVL_W'(8)) begin n_err++; $display("FAIL b2b_prefill got=%0d exp=8", level); end
    for (int i = 0; i < 20; i++) begin
      cyc(1, rnd128(), 1, 0);
      n_cmp++; if (level !== LVL_W'(8)) begin n_err++; $display("FAIL b2b_level got=%0d exp=8", level); end
      n_cmp++; if (rdata !== m_data) begin n_err++; $display("FAIL b2b_data got=%h exp=%h", rdata, m_data); end
    end
    for (int i = 0; i < 8; i++) begin
      cyc(0, '0, 1, 0);
      n_cmp++; if (rdata !== m_data) begin n_err++; $display("FAIL b2b_drain got=%h exp=%h", rdata, m_data); end
    end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL b2b_empty got=%b exp=1", empty); end
  endtask

  task automatic test_eof();
    for (int i = 0; i < 3; i++) cyc(1, rnd128(), 0, 0);
    cyc(0, '0, 0, 1);
    n_cmp++; if (ap_full_n !== 1'b0) begin n_err++; $display("FAIL eof_backpressure got=%b exp=0", ap_full_n); end
    cyc(1, rnd128(), 0, 0);
    n_cmp++; if (level !== LVL_W'(3)) begin n_err++; $display("FAIL eof_drop_level got=%0d exp=3", level); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (eof !== 1'b0) begin n_err++; $display("FAIL eof_early got=%b exp=0 before read %0d", eof, i); end
      cyc(0, '0, 1, 0);
      n_cmp++; if (rdata !== m_data) begin n_err++; $display("FAIL eof_data got=%h exp=%h", rdata, m_data); end
    end
    n_cmp++; if (empty !== 1'b1 || eof !== 1'b1) begin n_err++; $display("FAIL eof_final got=%b%b exp=11", empty, eof); end
    open = 1'b0;
    cyc(0, '0, 0, 0);
    n_cmp++; if (eof !== 1'b0) begin n_err++; $display("FAIL eof_close got=%b exp=0", eof); end
    open = 1'b1;
    cyc(0, '0, 0, 0);
    n_cmp++; if (ap_full_n !== 1'b1) begin n_err++; $display("FAIL eof_reopen_full_n got=%b exp=1", ap_full_n); end
  endtask

  task automatic test_close();
    logic [WORD_W-1:0] w;
    for (int i = 0; i < 5; i++) cyc(1, rnd128(), 0, 0);
    cyc(0, '0, 1, 0);
    cyc(0, '0, 1, 0);
    open = 1'b0;
    cyc(0, '0, 0, 0);
    n_cmp++; if (level !== '0) begin n_err++; $display("FAIL close_level got=%0d exp=0", level); end
    n_cmp++; if (eof !== 1'b0 || empty !== 1'b1) begin n_err++; $display("FAIL close_flags got=%b%b exp=10", eof, empty); end
    n_cmp++; if (word_count !== 32'd0) begin n_err++; $display("FAIL close_wc got=%0d exp=0", word_count); end
    n_cmp++; if (rdata !== '0) begin n_err++; $display("FAIL close_data got=%h exp=0", rdata); end
    open = 1'b1;
    cyc(0, '0, 0, 0);
    w = rnd128();
    cyc(1, w, 0, 0);
    cyc(0, '0, 1, 0);
    n_cmp++; if (rdata !== w) begin n_err++; $display("FAIL reopen_data got=%h exp=%h", rdata, w); end
    n_cmp++; if (word_count !== exp_wc()) begin n_err++; $display("FAIL reopen_wc got=%0d exp=%0d", word_count, exp_wc()); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      open = ($urandom_range(0, 39) != 0);
      cyc($urandom_range(0, 2) != 0, rnd128(), $urandom_range(0, 2) != 0,
          $urandom_range(0, 59) == 0);
      n_cmp++; if (level !== LVL_W'(q.size())) begin n_err++; $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", i, level, q.size()); end
      n_cmp++; if (rdata !== m_data) begin n_err++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", i, rdata, m_data); end
      n_cmp++; if (empty !== (q.size() == 0)) begin n_err++; $display("FAIL rnd_empty cyc=%0d got=%b", i, empty); end
      n_cmp++; if (eof !== (m_eofp && q.size() == 0)) begin n_err++; $display("FAIL rnd_eof cyc=%0d got=%b", i, eof); end
      n_cmp++; if (ap_full_n !== m_full_n) begin n_err++; $display("FAIL rnd_full_n cyc=%0d got=%b exp=%b", i, ap_full_n, m_full_n); end
      n_cmp++; if (word_count !== exp_wc()) begin n_err++; $display("FAIL rnd_wc cyc=%0d got=%0d exp=%0d", i, word_count, exp_wc()); end
    end
    open = 1'b1;
  endtask

  task automatic test_async_reset();
    open = 1'b1;
    cyc(0, '0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, rnd128(), 0, 0);
    cyc(0, '0, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    n_cmp++; if (level !== '0) begin n_err++; $display("FAIL async_rst_level got=%0d exp=0", level); end
    n_cmp++; if (rdata !== '0) begin n_err++; $display("FAIL async_rst_data got=%h exp=0", rdata); end
    n_cmp++; if (ap_full_n !== 1'b0) begin n_err++; $display("FAIL async_rst_full_n got=%b exp=0", ap_full_n); end
    @(posedge bus_clk); #1;
    rst = 1'b0;
    cyc(0, '0, 0, 0);
    n_cmp++; if (ap_full_n !== 1'b1) begin n_err++; $display("FAIL async_rst_recover got=%b exp=1", ap_full_n); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_eof();
    test_close();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/xilly_read_source.md
# xilly_read_source

Application-side source for one Xillybus 128-bit read stream (host reads from FPGA). It accepts words from an HLS `ap_fifo`-style producer, buffers them in a small synchronous FIFO, and serves them on the `user_r_read_128_*` handshake (rden/data/empty/eof/open) driven by the Xillybus core. It sits between the accelerator output and the core, one instance per read channel (1–4).

## Interface
Parameters:
- `DEPTH`, 16: buffer entries; power of two, 4..512.
- `WORD_W`, 128: word width in bits.

Ports:
- `bus_clk` in 1: single clock, the Xillybus bus clock.
- `rst` in 1: asynchronous, active-high reset.
- `ap_din` in WORD_W: producer data.
- `ap_write` in 1: producer write strobe.
- `ap_full_n` out 1: producer may write.
- `eof_req` in 1: one-cycle pulse; end of stream after buffered data drains.
- `user_r_read_128_rden` in 1: core read strobe.
- `user_r_read_128_data` out WORD_W: read data, registered.
- `user_r_read_128_empty` out 1: no word available.
- `user_r_read_128_eof` out 1: end of file; only ever asserted together with empty.
- `user_r_read_128_open` in 1: host has the device file open.
- `level` out $clog2(DEPTH)+1: words currently buffered.
- `word_count` out 32: words delivered since open (see Configuration).

## Operation
- **Reset values:** count=0, pointers=0, data=0, empty=1, eof=0, ap_full_n=0, eof_pending=0, word_count=0.
- **Write acceptance:** `ap_full_n = open && !full && !eof_pending`. A write is accepted when `ap_write && ap_full_n`. When `ap_write` is asserted with `ap_full_n=0`, the write is dropped silently and no state changes.
- **Read acceptance:** a read is accepted when `rden && !empty`. `rden` while empty is ignored: pointers and count are unchanged and data holds its value.
- **Simultaneous write and read:** both take effect and count is unchanged.
  - When full, the read frees an entry but `ap_full_n` stays 0 that cycle. It is computed from registered state, with no combinational path from `rden`.
  - When empty, only the write occurs.
- **Empty flag:** `empty = (count==0)`, combinational from registered count.
- **EOF:**
  - `eof_req` while open sets `eof_pending`. `eof_req` while closed is ignored.
  - `eof = eof_pending && empty`, so EOF is reported only after the last buffered word has been read.
  - After `eof_pending` is set, the producer is back-pressured until close.
- **Close:** when `open` is low on a clock edge, the block flushes. Pointers, count, `eof_pending`, data and `word_count` are cleared, so a later reopen starts clean. Rising `open` takes no action.
- **Pointer arithmetic:** pointers are log2(DEPTH) bits and wrap naturally at DEPTH.

## Timing
- **Read latency:** `rden` sampled at edge N; `user_r_read_128_data` holds the word from edge N onward. This is the standard (non-FWFT) FIFO timing the core expects.
- **Write to visible:** write accepted at edge N; `empty` deasserts after edge N, so the first `rden` can be at edge N+1.
- **Full recovery:** read at edge N; `ap_full_n` rises after edge N.
- **EOF:** last word read at edge N; empty=1 and eof=1 after edge N (same cycle), provided `eof_pending` is already set.
- **Reset:** asynchronous assertion clears all state immediately. Deassertion is assumed synchronized upstream.

## Configuration
- `XILLY_SRC_WORDCOUNT_EN` defined: `word_count` is a 32-bit counter. It increments on each accepted read, wraps at 2^32, and clears on reset and on close.
- Not defined: `word_count` is tied to 0 and the counter logic is not built.
- The port list is identical in both cases.

## Structure
- **Package `xilly_src_pkg`:** default `WORD_W`=128, default `DEPTH`=16, and a `level_w(depth)` function returning $clog2(depth)+1.
- **Sub-module `xilly_src_fifo`:** a synchronous FIFO (storage array, wr/rd pointers, count, registered read port, sync flush input).
- **Top level:** open/EOF control, handshake gating and the optional counter.

## Test plan
1. Reset with `open=1`, idle → empty=1, eof=0, ap_full_n=1 after the first edge, data=0, level=0.
2. Write 0x…01 to 0x…10 (16 words, DEPTH=16) with no reads → ap_full_n=0 after the 16th write. A 17th `ap_write` is dropped; level=16.
3. Read all 16 words back with back-to-back `rden` → each word appears one cycle after its `rden`, in order 0x…01..0x…10. Then empty=1; `rden` while empty leaves data at 0x…10.
4. Level=8, then simultaneous write and read for 20 cycles → level stays 8, data arrives in order, no loss. Pointer wrap is exercised.
5. Write 3 words, pulse `eof_req`, then `ap_write` → the post-EOF write is rejected (ap_full_n=0). eof=0 until the third read, then empty=1 and eof=1 in the same cycle.
6. Write 5 words, read 2, drop `open` → level=0, eof=0, word_count=0. Reopen and write 1 word → that word is read first. With the macro defined, word_count=1 after the read.
